// File: rtl/button_pkg.sv
// Shared definitions for the 3-button sequence detector and its stimulus generator:
// button codes, generator state encoding and frame timing constants.
package button_pkg;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] B1   = 3'b001;
    localparam logic [2:0] B2   = 3'b010;
    localparam logic [2:0] B3B1 = 3'b101;
    localparam logic [2:0] B3B2 = 3'b110;

    // Detector-busy cycles after a confirm press, and idle spacers after the first press.
    localparam int TAIL_LEN   = 4;
    localparam int SPACER_LEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_WAIT1   = 3'd2,
        ST_WAIT2   = 3'd3,
        ST_CONFIRM = 3'd4,
        ST_TAIL    = 3'd5,
        ST_GAP     = 3'd6
    } gen_state_e;

    // Button code for a press of B1 (first=0) or B2 (first=1), optionally with B3 held.
    function automatic logic [2:0] press_code(input logic first, input logic b3);
        if (first) return b3 ? B3B2 : B2;
        else       return b3 ? B3B1 : B1;
    endfunction

endpackage

// File: rtl/button_seq_gen.sv
// Frame generator for the 3-button sequence detector: emits one press/spacer/confirm
// frame per accepted start, with a cycle-aligned prediction of the detector output.
module button_seq_gen
    import button_pkg::*;
#(
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmd_first,
    input  logic             cmd_b3,
    input  logic             cmd_long,
    output logic [2:0]       b,
    output logic             exp_outp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt,
    output gen_state_e       state_dbg
);

    localparam int             GW        = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0]  GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [1:0]     TAIL_LAST = 2'(TAIL_LEN - 1);

    gen_state_e    state, state_nxt;
    logic [1:0]    tail_cnt, tail_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          first_q, b3_q, long_q;
    logic          first_n, b3_n, long_n;
    logic          accept;
    logic [2:0]    b_nxt;
    logic          eo_nxt, done_nxt;

    assign accept    = (state == ST_IDLE) && start;
    assign state_dbg = state;

    // Command bits as they will be latched after this edge; outputs are
    // registered from the upcoming state, so they must see the new command.
    assign first_n = accept ? cmd_first : first_q;
    assign b3_n    = accept ? cmd_b3    : b3_q;
    assign long_n  = accept ? cmd_long  : long_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tail_cnt  <= '0;
            gap_cnt   <= '0;
            first_q   <= 1'b0;
            b3_q      <= 1'b0;
            long_q    <= 1'b0;
            b         <= NONE;
            exp_outp  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tail_cnt <= tail_nxt;
            gap_cnt  <= gap_nxt;
            if (accept) begin
                first_q <= cmd_first;
                b3_q    <= cmd_b3;
                long_q  <= cmd_long;
            end
            b        <= b_nxt;
            exp_outp <= eo_nxt;
            busy     <= (state_nxt != ST_IDLE);
            done     <= done_nxt;
            if (done) frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        tail_nxt  = '0;
        gap_nxt   = '0;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_PRESS;
            ST_PRESS:   state_nxt = ST_WAIT1;
            ST_WAIT1:   state_nxt = ST_WAIT2;
            ST_WAIT2:   state_nxt = ST_CONFIRM;
            ST_CONFIRM: begin
                if (long_q)       state_nxt = ST_TAIL;
                else if (GAP > 0) state_nxt = ST_GAP;
                else              state_nxt = ST_IDLE;
            end
            ST_TAIL: begin
                if (tail_cnt == TAIL_LAST) begin
                    state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    tail_nxt = tail_cnt + 2'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
                else                     gap_nxt   = gap_cnt + GW'(1);
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        b_nxt    = NONE;
        eo_nxt   = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            ST_PRESS: b_nxt = press_code(first_n, b3_n);
            ST_WAIT2: begin
                b_nxt  = {b3_n, 2'b00};
                eo_nxt = b3_n;
            end
            ST_CONFIRM: begin
                b_nxt    = long_n ? press_code(1'b1, b3_n) : NONE;
                eo_nxt   = 1'b1;
                done_nxt = (GAP == 0) && !long_n;
            end
            ST_TAIL:    done_nxt = (GAP == 0) && (tail_nxt == TAIL_LAST);
            ST_GAP:     done_nxt = (gap_nxt == GAP_LAST);
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_button_seq_gen.sv
// Bench for button_seq_gen (GAP=2, CNT_W=8): table-driven frames checked cycle by cycle
// through an expected-output queue, plus reset-abort, held-start and counter-wrap sequences.
module tb_button_seq_gen;
    import button_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cmd_first, cmd_b3, cmd_long;
    logic [2:0] b;
    logic       exp_outp, busy, done;
    logic [7:0] frame_cnt;
    gen_state_e state_dbg;

    button_seq_gen #(.GAP(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmd_first(cmd_first), .cmd_b3(cmd_b3), .cmd_long(cmd_long),
        .b(b), .exp_outp(exp_outp), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Expected record: {b[2:0], exp_outp, busy, done, frame_cnt[7:0]}
    logic [13:0] exp_q[$];
    int          tests  = 0;
    int          fails  = 0;
    int          cycle  = 0;
    logic [7:0]  exp_cnt = 8'd0;

    typedef struct {
        logic            first;
        logic            b3;
        logic            lng;
        int              len;
        logic [0:9][2:0] bseq;
        logic [0:9]      eo;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [13:0] rec(input logic [2:0] bv, input logic eo, input logic bz,
                                        input logic dn, input logic [7:0] cnt);
        return {bv, eo, bz, dn, cnt};
    endfunction

    task automatic push_idle();
        exp_q.push_back(rec(3'b000, 1'b0, 1'b0, 1'b0, exp_cnt));
    endtask

    // Drives one start and queues the frame plus the single idle cycle after it.
    // With noisy=1, start stays high and the cmd inputs churn while busy.
    task automatic drive_frame(input vec_t v, input bit noisy);
        start     = 1'b1;
        cmd_first = v.first;
        cmd_b3    = v.b3;
        cmd_long  = v.lng;
        @(posedge clk); #1;
        for (int i = 0; i < v.len; i++)
            exp_q.push_back(rec(v.bseq[i], v.eo[i], 1'b1, (i == v.len - 1), exp_cnt));
        exp_cnt = exp_cnt + 8'd1;
        push_idle();
        start = noisy;
        for (int c = 0; c < v.len; c++) begin
            if (noisy) begin
                cmd_first = 1'($urandom_range(0, 1));
                cmd_b3    = 1'($urandom_range(0, 1));
                cmd_long  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 6,  {3'b001, 27'b0},                         10'b0001000000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 10, {3'b110, 3'b000, 3'b100, 3'b110, 18'b0}, 10'b0011000000};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 6,  {3'b101, 3'b000, 3'b100, 21'b0},         10'b0011000000};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 10, {3'b010, 3'b000, 3'b000, 3'b010, 18'b0}, 10'b0001000000};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 10, {3'b101, 3'b000, 3'b100, 3'b110, 18'b0}, 10'b0011000000};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 6,  {3'b010, 27'b0},                         10'b0001000000};

        fork
            forever begin
                @(negedge clk);
                cycle++;
                if (exp_q.size() > 0) begin
                    logic [13:0] e;
                    e = exp_q.pop_front();
                    tests++;
                    if ({b, exp_outp, busy, done, frame_cnt} !== e) begin
                        fails++;
                        $display("FAIL cycle %0d outputs: b=%b eo=%b busy=%b done=%b cnt=%0d, expected b=%b eo=%b busy=%b done=%b cnt=%0d",
                                 cycle, b, exp_outp, busy, done, frame_cnt,
                                 e[13:11], e[10], e[9], e[8], e[7:0]);
                    end
                end
            end
        join_none

        // Reset, then ten idle cycles.
        rst_n = 1'b0; start = 1'b0; cmd_first = 1'b0; cmd_b3 = 1'b0; cmd_long = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (10) push_idle();
        repeat (10) @(posedge clk);
        #1;

        // Reset for one edge during CONFIRM of a long frame.
        start = 1'b1; cmd_first = 1'b1; cmd_b3 = 1'b1; cmd_long = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(rec(tbl[1].bseq[i], tbl[1].eo[i], 1'b1, 1'b0, exp_cnt));
        push_idle();
        repeat (3) @(posedge clk);
        #1;
        check("abort_in_confirm", 32'(state_dbg), 32'(ST_CONFIRM));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));

        // Table frames, back to back.
        for (int k = 0; k < 6; k++) drive_frame(tbl[k], 1'b0);

        // Start held high with churning commands mid-frame.
        for (int k = 0; k < 4; k++) drive_frame(tbl[(k * 5 + 1) % 6], 1'b1);

        // Clear the counter, then 256 short frames to wrap it.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        push_idle();
        for (int k = 0; k < 256; k++) drive_frame(tbl[0], 1'b0);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
